// File: rtl/hazard_ctrl.sv
// Issue-stage hazard controller: shift-register scoreboard of in-flight destinations, stall and stall statistics.
// Define HAZARD_CTRL_FWD_EN to resolve non-load-use dependences by forwarding instead of stalling.
module hazard_ctrl #(
  parameter int  REG_W    = 6,
  parameter int  DEPTH    = 3,
  parameter int  ZERO_REG = 0,
  parameter int  CNT_W    = 16,
  localparam int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [REG_W-1:0] rd,
  input  logic             rd_we,
  input  logic             is_load,
  input  logic             flush,
  input  logic             hold,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_rs1_sel,
  output logic [SEL_W-1:0] fwd_rs2_sel,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  logic [DEPTH-1:0] r_v;
  logic [DEPTH-1:0] r_ld;
  logic [REG_W-1:0] r_rd [DEPTH];
  logic [CNT_W-1:0] r_cnt;
  logic [DEPTH-1:0] w_m1;
  logic [DEPTH-1:0] w_m2;
  logic             w_hazard;
  logic             w_ins_v;
  logic             w_unused_ld;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_m1[i] = rs1_used && r_v[i] && (r_rd[i] == rs1) && (rs1 != ZR);
      w_m2[i] = rs2_used && r_v[i] && (r_rd[i] == rs2) && (rs2 != ZR);
    end
  end

`ifdef HAZARD_CTRL_FWD_EN
  // Only a load in e[0] has no result yet; everything else is forwarded from the youngest match.
  assign w_hazard = in_valid && r_ld[0] && (w_m1[0] || w_m2[0]);

  always_comb begin
    fwd_rs1_sel = '0;
    fwd_rs2_sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_m1[i]) fwd_rs1_sel = SEL_W'(i + 1);
      if (w_m2[i]) fwd_rs2_sel = SEL_W'(i + 1);
    end
    if (w_m1[0] && r_ld[0]) fwd_rs1_sel = '0;
    if (w_m2[0] && r_ld[0]) fwd_rs2_sel = '0;
    if (!in_valid || flush) begin
      fwd_rs1_sel = '0;
      fwd_rs2_sel = '0;
    end
  end
`else
  assign w_hazard    = in_valid && ((|w_m1) || (|w_m2));
  assign fwd_rs1_sel = '0;
  assign fwd_rs2_sel = '0;
`endif

  assign w_unused_ld  = ^r_ld;
  assign stall        = !flush && (hold || w_hazard);
  assign w_ins_v      = in_valid && rd_we && (rd != ZR) && !w_hazard;
  assign stall_cycles = r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v   <= '0;
      r_cnt <= '0;
    end else begin
      if (stall) r_cnt <= sat_inc(r_cnt);
      if (flush) r_v <= '0;
      else if (!hold) r_v <= (r_v << 1) | DEPTH'(w_ins_v);
    end
  end

  // Entry payload needs no reset: it is only ever qualified by r_v.
  always_ff @(posedge clk) begin
    if (!flush && !hold) begin
      r_rd[0] <= rd;
      r_ld    <= (r_ld << 1) | DEPTH'(is_load);
      for (int i = 1; i < DEPTH; i++) r_rd[i] <= r_rd[i-1];
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised and directed bench for hazard_ctrl against a queue-based scoreboard model.
module tb_hazard_ctrl;
  localparam int DEPTH = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, rs1_used, rs2_used, rd_we, is_load, flush, hold;
  logic [5:0]  rs1, rs2, rd;
  logic        stall, stall4;
  logic [1:0]  sel1, sel2, sel1_4, sel2_4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .rs1(rs1), .rs2(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .rd(rd), .rd_we(rd_we),
    .is_load(is_load), .flush(flush), .hold(hold), .stall(stall),
    .fwd_rs1_sel(sel1), .fwd_rs2_sel(sel2), .stall_cycles(cnt)
  );

  hazard_ctrl #(.CNT_W(4)) u_dut_c4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .rs1(rs1), .rs2(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .rd(rd), .rd_we(rd_we),
    .is_load(is_load), .flush(flush), .hold(hold), .stall(stall4),
    .fwd_rs1_sel(sel1_4), .fwd_rs2_sel(sel2_4), .stall_cycles(cnt4)
  );

  typedef struct packed {
    logic       v;
    logic [5:0] rd;
    logic       ld;
  } ent_t;

  ent_t sb[$];
  int   m_cnt, m_cnt4;
  int   n_chk, n_pass;
  int   c0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
  endtask

  // Index of the youngest in-flight producer of rs, or -1.
  function automatic int youngest(input logic [5:0] rs, input logic used);
    if (!used || rs == 6'd0) return -1;
    for (int k = 0; k < sb.size(); k++)
      if (sb[k].v && sb[k].rd == rs) return k;
    return -1;
  endfunction

  task automatic cyc(input bit v, input int a1, input bit u1, input int a2, input bit u2,
                     input int d, input bit we, input bit ld, input bit fl, input bit hd);
    int y1, y2, s1, s2;
    bit hz, st;
    ent_t e;
    @(negedge clk);
    in_valid = v; rs1 = 6'(a1); rs1_used = u1; rs2 = 6'(a2); rs2_used = u2;
    rd = 6'(d); rd_we = we; is_load = ld; flush = fl; hold = hd;
    #1;
    y1 = youngest(rs1, rs1_used);
    y2 = youngest(rs2, rs2_used);
`ifdef HAZARD_CTRL_FWD_EN
    hz = v && ((y1 == 0 && sb[0].ld) || (y2 == 0 && sb[0].ld));
    s1 = (!v || fl || y1 < 0 || (y1 == 0 && sb[0].ld)) ? 0 : y1 + 1;
    s2 = (!v || fl || y2 < 0 || (y2 == 0 && sb[0].ld)) ? 0 : y2 + 1;
`else
    hz = v && (y1 >= 0 || y2 >= 0);
    s1 = 0;
    s2 = 0;
`endif
    st = !fl && (hd || hz);
    chk("stall", stall, st);
    chk("sel1", sel1, s1);
    chk("sel2", sel2, s2);
    chk("cnt", cnt, m_cnt);
    chk("stall_c4", stall4, st);
    chk("cnt_c4", cnt4, m_cnt4);
    @(posedge clk);
    if (st) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (fl) sb.delete();
    else if (!hd) begin
      e.v = v && we && (d != 0) && !hz;
      e.rd = 6'(d);
      e.ld = ld;
      sb.push_front(e);
      if (sb.size() > DEPTH) void'(sb.pop_back());
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic snap();
    #1 c0 = cnt;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; m_cnt = 0; m_cnt4 = 0;
    reset = 1'b0; in_valid = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
    rd = 0; rd_we = 0; is_load = 0; flush = 0; hold = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_stall", stall, 0);
    chk("reset_sel1", sel1, 0);
    chk("reset_sel2", sel2, 0);
    chk("reset_cnt", cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    idle();

    // ADD r5 then dependent SUB
    snap();
    cyc(1, 1, 1, 2, 1, 5, 1, 0, 0, 0);
    repeat (4) cyc(1, 5, 1, 3, 1, 8, 1, 0, 0, 0);
`ifndef HAZARD_CTRL_FWD_EN
    chk("stall_len3", cnt - 16'(c0), 3);
`endif
    idle(); idle(); idle();

    // one independent instruction in between
    snap();
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 5, 1, 10, 1, 0, 0, 0);
`ifndef HAZARD_CTRL_FWD_EN
    chk("stall_len2", cnt - 16'(c0), 2);
`endif
    idle(); idle(); idle();

    // ZERO_REG never hazards
    snap();
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 1, 11, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 12, 1, 0, 0, 0);
    chk("zero_reg", cnt - 16'(c0), 0);
    idle(); idle(); idle();

    // flush in the middle of a stall
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    cyc(1, 5, 1, 0, 0, 13, 1, 0, 0, 0);
    cyc(1, 5, 1, 0, 0, 13, 1, 0, 0, 1'b1 ? 0 : 0);
    cyc(1, 5, 1, 0, 0, 13, 1, 0, 1, 0);
    cyc(1, 5, 1, 0, 0, 13, 1, 0, 0, 0);
    idle(); idle(); idle();

    // hold freezes a tracked producer
    cyc(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    repeat (4) cyc(1, 9, 1, 0, 0, 14, 1, 0, 0, 1);
    repeat (4) cyc(1, 9, 1, 0, 0, 14, 1, 0, 0, 0);
    idle(); idle(); idle();

    // forwarding patterns: ALU producer, load-use, two producers
    cyc(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    cyc(1, 4, 1, 0, 0, 15, 1, 0, 0, 0);
    idle(); idle(); idle();
    cyc(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
    repeat (4) cyc(1, 4, 1, 0, 0, 16, 1, 0, 0, 0);
    idle(); idle(); idle();
    cyc(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    repeat (3) cyc(1, 4, 1, 6, 1, 17, 1, 0, 0, 0);
    idle(); idle(); idle();

    // asynchronous reset while a dependent instruction is stalled
    cyc(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    cyc(1, 5, 1, 0, 0, 18, 1, 0, 0, 0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_stall", stall, 0);
    chk("async_sel1", sel1, 0);
    chk("async_cnt", cnt, 0);
    chk("async_cnt_c4", cnt4, 0);
    sb.delete();
    m_cnt = 0;
    m_cnt4 = 0;
    @(negedge clk);
    in_valid = 0; rd_we = 0; hold = 0; flush = 0;
    reset = 1'b1;
    idle();

    // counter saturation on the narrow instance
    repeat (21) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    #1;
    chk("sat_c4", cnt4, 15);
    chk("nosat_16", cnt, 21);

    for (int n = 0; n < 300; n++) begin
      cyc(($urandom_range(0, 9) < 8), $urandom_range(0, 7), $urandom_range(0, 1),
          $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
          $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 5) == 0));
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
